barrel_shifter_pipe: RTL
========================

BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 SHALL have parameter BITS, default 32, meaning data width; legal values are powers of two from 8 to 64.
REQ-002 SHALL have derived localparam SHW = $clog2(BITS), meaning the shift-amount width is SHW+1 bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning the input operands are valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts the input this cycle.
REQ-007 SHALL have port data, input, BITS, the operand.
REQ-008 SHALL have port shamt, input, SHW+1, the unsigned shift amount, 0..2*BITS-1.
REQ-009 SHALL have port dir, input, 1, the direction: 0 = left, 1 = right.
REQ-010 SHALL have port arith, input, 1, selecting fill for right shifts: 1 = sign fill, 0 = zero fill; it is ignored for left shifts.
REQ-011 SHALL have port out_valid, output, 1, meaning shifted_data is valid.
REQ-012 SHALL have port out_ready, input, 1, the downstream accept.
REQ-013 SHALL have port shifted_data, output, BITS, the result.
REQ-014 SHALL have port sticky, output, 1, the OR of all data bits shifted out past bit 0; present only under the macro in REQ-031.

Function
REQ-015 SHALL implement a logarithmic shifter of SHW stages; stage k shifts by 2^k when shamt[k] is set.
- Each stage is followed by a pipeline register.
- Latency is exactly SHW cycles from accept to out_valid, with no stall.
REQ-016 SHALL treat shamt >= BITS (shamt[SHW] set) as a full shift-out.
- Left or logical right: result 0.
- Arithmetic right: result all copies of data[BITS-1].
REQ-017 SHALL shift left by filling vacated LSBs with 0.
REQ-018 SHALL shift right by filling vacated MSBs with 0, or with data[BITS-1] when arith=1.
REQ-019 SHALL carry dir, arith and a per-stage valid bit alongside the data through every stage.
REQ-020 SHALL define advance = !out_valid | out_ready, and SHALL drive in_ready = advance.
REQ-021 SHALL shift all pipeline registers, including valid bits, only when advance=1, and SHALL hold them unchanged otherwise.
REQ-022 SHALL accept a transaction only when in_valid & in_ready.
- On a cycle that advances with no accept, a bubble (valid=0) enters stage 0.
REQ-023 SHALL sustain a throughput of one result per cycle when out_ready is held at 1.
REQ-024 SHALL hold shifted_data and sticky stable while out_valid=1 and out_ready=0.
REQ-025 SHALL apply a shamt of 0 as a pass-through: shifted_data = data, sticky = 0.
REQ-026 SHALL let simultaneous accept and output handshake proceed in the same cycle without loss or duplication.

Reset
REQ-027 SHALL clear all stage valid bits and out_valid to 0 on rst=1 at a clock edge.
REQ-028 SHALL clear shifted_data and sticky to 0 on reset.
REQ-029 SHALL discard in-flight transactions when reset is asserted mid-operation, and SHALL produce no output for them after reset.
REQ-030 SHALL drive in_ready=1 during and after reset, so an input may be accepted the first cycle after rst deasserts.

Configuration
REQ-031 SHALL compile in sticky-bit logic when macro BARREL_SHIFTER_STICKY_EN is defined.
- Right shift: each stage ORs the bits it discards into a sticky register carried with the data.
- Left shift: sticky = 0.
- Full shift-out (REQ-016) on a right shift: sticky = OR of all data bits.
REQ-032 SHALL, without BARREL_SHIFTER_STICKY_EN, omit the sticky port and all of its registers; all other behaviour is identical.

Verification
REQ-033 SHALL cover a left shift: BITS=32, data=0x0000_00F1, shamt=4, dir=0 -> shifted_data=0x0000_0F10 exactly 5 cycles after accept, with sticky=0.
REQ-034 SHALL cover right shifts with data=0x8000_0013, shamt=3, dir=1:
- arith=1 -> shifted_data=0xF000_0002, sticky=1.
- arith=0 -> shifted_data=0x1000_0002, sticky=1.
REQ-035 SHALL cover full shift-out with data=0x8000_0001, shamt=40, dir=1, arith=1 -> shifted_data=0xFFFF_FFFF, sticky=1.
- Same operands with dir=0 -> shifted_data=0, sticky=0.
REQ-036 SHALL cover back-to-back traffic: 8 consecutive accepts with out_ready=1 -> 8 results in order on 8 consecutive cycles.
- Then hold out_ready=0 for 3 cycles -> in_ready=0, and the output is held.
- After release, there is no loss or duplication.
REQ-037 SHALL cover reset mid-operation: assert rst with 3 transactions in flight -> out_valid stays 0 until new inputs are accepted, and shifted_data=0 right after reset.
REQ-038 SHALL cover a shamt=0 sweep: random data for both dir values -> shifted_data=data, sticky=0.

Source files
------------

// File: rtl/barrel_shifter_pipe_if.sv
// barrel_shifter_pipe_if
//   Operand/result bundle for barrel_shifter_pipe.
//   master: the side that supplies operands and consumes results.
//   slave : the shifter itself.
//   Signals:
//     in_valid/in_ready   - operand handshake
//     data, shamt, dir, arith - operand (shamt is SHW+1 bits)
//     out_valid/out_ready - result handshake
//     shifted_data        - result
//     sticky              - OR of bits shifted out to the right
//                           (only when BARREL_SHIFTER_STICKY_EN is defined)
interface barrel_shifter_pipe_if #(
  parameter int BITS = 32
);
  localparam int SHW = $clog2(BITS);

  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] data;
  logic [SHW:0]    shamt;
  logic            dir;
  logic            arith;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] shifted_data;
`ifdef BARREL_SHIFTER_STICKY_EN
  logic            sticky;

  modport master (
    output in_valid, data, shamt, dir, arith, out_ready,
    input  in_ready, out_valid, shifted_data, sticky
  );
  modport slave (
    input  in_valid, data, shamt, dir, arith, out_ready,
    output in_ready, out_valid, shifted_data, sticky
  );
`else
  modport master (
    output in_valid, data, shamt, dir, arith, out_ready,
    input  in_ready, out_valid, shifted_data
  );
  modport slave (
    input  in_valid, data, shamt, dir, arith, out_ready,
    output in_ready, out_valid, shifted_data
  );
`endif
endinterface

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe
//   Pipelined logarithmic barrel shifter. SHW = $clog2(BITS) stages, stage k
//   shifts by 2^k when shamt[k] is set, each stage registered. Latency is SHW
//   cycles; one result per cycle when out_ready stays high. The whole pipe
//   advances only when the output register is empty or being taken.
//   Parameters:
//     BITS - data width, power of two 8..64
//   Ports:
//     clk - rising-edge clock
//     rst - synchronous active-high reset
//     bus - barrel_shifter_pipe_if.slave (operand/result handshakes)
//   Optional feature:
//     BARREL_SHIFTER_STICKY_EN - adds the sticky output and its registers.
module barrel_shifter_pipe #(
  parameter int BITS = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  barrel_shifter_pipe_if.slave        bus
);
  localparam int SHW = $clog2(BITS);
  localparam logic [BITS-1:0] ONES = '1;

  typedef struct packed {
    logic            valid;
    logic            dir;
    logic            arith;
    logic [SHW-1:0]  amt;
`ifdef BARREL_SHIFTER_STICKY_EN
    logic            sticky;
`endif
    logic [BITS-1:0] data;
  } stage_t;

  stage_t stg_q [SHW];
  stage_t src   [SHW];
  stage_t stg_d [SHW];
  logic   advance;

  assign advance          = !stg_q[SHW-1].valid | bus.out_ready;
  assign bus.in_ready     = advance;
  assign bus.out_valid    = stg_q[SHW-1].valid;
  assign bus.shifted_data = stg_q[SHW-1].data;
`ifdef BARREL_SHIFTER_STICKY_EN
  assign bus.sticky       = stg_q[SHW-1].sticky;
`endif

  always_comb begin
    // Stage 0 input. A shamt >= BITS is resolved here into the fill pattern
    // with the remaining amount cleared, so later stages simply pass it on.
    src[0]       = '0;
    src[0].valid = bus.in_valid & advance;
    src[0].dir   = bus.dir;
    src[0].arith = bus.arith;
    src[0].amt   = bus.shamt[SHW-1:0];
    src[0].data  = bus.data;
    if (bus.shamt[SHW]) begin
      src[0].amt  = '0;
      src[0].data = (bus.dir & bus.arith & bus.data[BITS-1]) ? ONES : '0;
`ifdef BARREL_SHIFTER_STICKY_EN
      src[0].sticky = bus.dir & (|bus.data);
`endif
    end
    for (int unsigned k = 1; k < SHW; k++) begin
      src[k] = stg_q[k-1];
    end

    // An arithmetic right shift keeps the original sign in the MSB after
    // every stage, so each stage can take its fill bit from its own input.
    for (int unsigned k = 0; k < SHW; k++) begin
      stg_d[k] = src[k];
      if (src[k].amt[k]) begin
        if (src[k].dir) begin
          stg_d[k].data = (src[k].data >> (1 << k)) |
                          ({BITS{src[k].arith & src[k].data[BITS-1]}} &
                           ~(ONES >> (1 << k)));
`ifdef BARREL_SHIFTER_STICKY_EN
          stg_d[k].sticky = src[k].sticky |
                            (|(src[k].data & ~(ONES << (1 << k))));
`endif
        end else begin
          stg_d[k].data = src[k].data << (1 << k);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < SHW; k++) begin
        stg_q[k] <= '0;
      end
    end else if (advance) begin
      for (int unsigned k = 0; k < SHW; k++) begin
        stg_q[k] <= stg_d[k];
      end
    end
  end
endmodule
